uno_horner_eval: RTL and testbench

//  Iterative fixed-point polynomial evaluator for PE unary ops (div/exp/log), directly downstream of the

---
 rtl/uno_horner_eval_pkg.sv | 48 ++++
 rtl/uno_coef_rf.sv | 50 +++++
 rtl/uno_horner_eval.sv | 136 +++++++++++++
 tb/tb_uno_horner_eval.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uno_horner_eval_pkg.sv
// uno_horner_eval_pkg
//   Shared definitions for the PE unary-op polynomial evaluator:
//   - Q-format constants (sign + INT_BW integer + FRA_BW fraction bits)
//   - unary op encoding and evaluator FSM state encoding
//   - sat_add: adds a coefficient to a wide shifted product and clamps
//     the result to the MUL_BW signed range.
package uno_horner_eval_pkg;

  localparam int INT_BW  = 5;
  localparam int FRA_BW  = 10;
  localparam int MUL_BW  = 1 + INT_BW + FRA_BW;
  localparam int PROD_BW = 2 * MUL_BW;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } uno_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    DONE = 2'b10
  } state_e;

  // The shifted product can be far outside the MUL_BW range (e.g. max*max),
  // so the add is done one bit wider than the product and clamped from there;
  // narrowing before the add would let large products wrap instead of clamp.
  function automatic logic signed [MUL_BW-1:0] sat_add(
    input logic signed [PROD_BW-1:0] a,
    input logic signed [MUL_BW-1:0]  c
  );
    logic signed [PROD_BW:0] sum;
    logic [PROD_BW-MUL_BW+1:0] top;
    sum = $signed({a[PROD_BW-1], a}) +
          $signed({{(PROD_BW+1-MUL_BW){c[MUL_BW-1]}}, c});
    // In range iff every bit from the result sign bit upward agrees.
    top = sum[PROD_BW:MUL_BW-1];
    if (top == '0 || top == '1)
      sat_add = sum[MUL_BW-1:0];
    else if (sum[PROD_BW])
      sat_add = {1'b1, {(MUL_BW-1){1'b0}}};
    else
      sat_add = {1'b0, {(MUL_BW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/uno_coef_rf.sv
// uno_coef_rf
//   Per-op coefficient table: 3 rows (div/exp/log) x TERMS entries of MUL_BW.
//   One synchronous write port, one asynchronous read port. Op code 00 (gemm)
//   has no row: writes to it are ignored and reads from it return 0.
// Ports
//   clk, rst_n          clock, async active-low reset (clears the table)
//   we_i                write strobe (caller qualifies it with FSM state)
//   wop_i/widx_i/wdata_i write row (op code), entry index, data
//   rop_i/ridx_i        read row (op code), entry index
//   rdata_o             read data
module uno_coef_rf
  import uno_horner_eval_pkg::*;
#(
  parameter int TERMS = 4,
  parameter int IW    = (TERMS > 1) ? $clog2(TERMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [1:0]               wop_i,
  input  logic [IW-1:0]            widx_i,
  input  logic signed [MUL_BW-1:0] wdata_i,
  input  logic [1:0]               rop_i,
  input  logic [IW-1:0]            ridx_i,
  output logic signed [MUL_BW-1:0] rdata_o
);

  logic [2:0][TERMS-1:0][MUL_BW-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int t = 0; t < TERMS; t++) begin
          if (wop_i == 2'(r + 1) && widx_i == IW'(t))
            mem_q[r][t] <= wdata_i;
        end
      end
    end
  end

  // Guard the index so a non-power-of-two TERMS never reads past the table.
  always_comb begin
    rdata_o = '0;
    if (rop_i != 2'b00 && {1'b0, ridx_i} < (IW+1)'(TERMS))
      rdata_o = mem_q[rop_i - 2'd1][ridx_i];
  end

endmodule

// File: rtl/uno_horner_eval.sv
// uno_horner_eval
//   Iterative fixed-point polynomial evaluator for PE unary ops. Accepts a
//   variable v (Q INT_BW.FRA_BW) and evaluates sum c[op][k]*v^k by Horner's
//   rule on a single shared multiplier, one term per cycle. The normalisation
//   shift and op code ride along as sideband for the post-scale stage.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   gemm_uno                   op select (00 gemm never starts an evaluation)
//   in_valid/in_ready          input handshake for var_i/shift_i/gemm_uno
//   var_i, shift_i             polynomial variable, shift sideband
//   coef_we/op/idx/data        coefficient table write (honoured only in IDLE)
//   out_valid/out_ready        output handshake
//   res_o, shift_o, op_o       result and sideband captured at accept
module uno_horner_eval
  import uno_horner_eval_pkg::*;
#(
  parameter int TERMS = 4,
  parameter int IW    = (TERMS > 1) ? $clog2(TERMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               gemm_uno,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [MUL_BW-1:0] var_i,
  input  logic [4:0]               shift_i,
  input  logic                     coef_we,
  input  logic [1:0]               coef_op,
  input  logic [IW-1:0]            coef_idx,
  input  logic signed [MUL_BW-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [MUL_BW-1:0] res_o,
  output logic [4:0]               shift_o,
  output logic [1:0]               op_o
);

  state_e                     state_q, state_d;
  logic [IW-1:0]              k_q, k_d;
  logic signed [MUL_BW-1:0]   acc_q, acc_d;
  logic signed [MUL_BW-1:0]   v_q, v_d;
  logic [1:0]                 op_q, op_d;
  logic [4:0]                 shift_q, shift_d;

  logic                       accept;
  logic                       rf_we;
  logic [1:0]                 rf_rop;
  logic [IW-1:0]              rf_ridx;
  logic signed [MUL_BW-1:0]   coef_rd;
  logic signed [PROD_BW-1:0]  prod;
  logic signed [PROD_BW-1:0]  prod_sh;

  assign in_ready = (state_q == IDLE) && (gemm_uno != GEMM);
  assign accept   = in_valid && in_ready;

  // Table only changes while idle, so an evaluation always sees one table.
  assign rf_we = coef_we && (state_q == IDLE) && (coef_op != GEMM);

  // The single read port serves the accept (top coefficient of the incoming
  // op) while idle, and the running term index while evaluating. A write in
  // the accept cycle therefore lands after the top coefficient was read.
  assign rf_rop  = (state_q == IDLE) ? gemm_uno : op_q;
  assign rf_ridx = (state_q == IDLE) ? IW'(TERMS - 1) : k_q;

  uno_coef_rf #(.TERMS(TERMS), .IW(IW)) u_coef_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (rf_we),
    .wop_i   (coef_op),
    .widx_i  (coef_idx),
    .wdata_i (coef_data),
    .rop_i   (rf_rop),
    .ridx_i  (rf_ridx),
    .rdata_o (coef_rd)
  );

  // Full-width signed product; >>> floors (truncates toward -inf).
  assign prod    = $signed(PROD_BW'(acc_q)) * $signed(PROD_BW'(v_q));
  assign prod_sh = prod >>> FRA_BW;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    v_d     = v_q;
    op_d    = op_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EVAL;
          acc_d   = coef_rd;
          k_d     = IW'(TERMS - 2);
          v_d     = var_i;
          op_d    = gemm_uno;
          shift_d = shift_i;
        end
      end
      EVAL: begin
        acc_d = sat_add(prod_sh, coef_rd);
        if (k_q == '0) state_d = DONE;
        else           k_d     = k_q - IW'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      v_q     <= '0;
      op_q    <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      v_q     <= v_d;
      op_q    <= op_d;
      shift_q <= shift_d;
    end
  end

  // Outputs are straight from registers; they only move on accept/EVAL, so
  // they hold steady through a stalled DONE.
  assign out_valid = (state_q == DONE);
  assign res_o     = acc_q;
  assign shift_o   = shift_q;
  assign op_o      = op_q;

endmodule

// File: tb/tb_uno_horner_eval.sv
module tb_uno_horner_eval;
  import uno_horner_eval_pkg::*;

  localparam int TERMS = 4;
  localparam int IW    = $clog2(TERMS);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [1:0]               gemm_uno = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [MUL_BW-1:0] var_i = '0;
  logic [4:0]               shift_i = '0;
  logic                     coef_we = 1'b0;
  logic [1:0]               coef_op = '0;
  logic [IW-1:0]            coef_idx = '0;
  logic signed [MUL_BW-1:0] coef_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [MUL_BW-1:0] res_o;
  logic [4:0]               shift_o;
  logic [1:0]               op_o;

  uno_horner_eval #(.TERMS(TERMS)) dut (
    .clk(clk), .rst_n(rst_n), .gemm_uno(gemm_uno), .in_valid(in_valid),
    .in_ready(in_ready), .var_i(var_i), .shift_i(shift_i), .coef_we(coef_we),
    .coef_op(coef_op), .coef_idx(coef_idx), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .res_o(res_o),
    .shift_o(shift_o), .op_o(op_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ref_c [1:3][0:TERMS-1];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Plain-arithmetic Horner with floor division by 2^FRA_BW.
  function automatic longint horner(input longint ctop, input int op, input longint v);
    longint acc;
    acc = ctop;
    for (int k = TERMS - 2; k >= 0; k--)
      acc = sat16(((acc * v) >>> FRA_BW) + longint'(ref_c[op][k]));
    return acc;
  endfunction

  task automatic wr(input int op, input int idx, input int data);
    @(negedge clk);
    coef_we = 1'b1; coef_op = 2'(op); coef_idx = IW'(idx); coef_data = MUL_BW'(data);
    @(negedge clk);
    coef_we = 1'b0;
    if (op != 0) ref_c[op][idx] = data;
  endtask

  // One evaluation. hold: stall out_ready 3 cycles at DONE. drop_wr: attempt
  // a coefficient write during EVAL (must be ignored). acc_wr: write in the
  // same cycle as the accept.
  task automatic run(input int op, input int v, input int sh, input bit hold,
                     input bit drop_wr, input bit acc_wr, input int wr_idx,
                     input int wr_data);
    longint expv, ctop;
    int lat;
    bit got;
    logic signed [MUL_BW-1:0] held;
    @(negedge clk);
    gemm_uno = 2'(op); in_valid = 1'b1; var_i = MUL_BW'(v); shift_i = 5'(sh);
    out_ready = !hold;
    if (acc_wr) begin
      coef_we = 1'b1; coef_op = 2'(op); coef_idx = IW'(wr_idx); coef_data = MUL_BW'(wr_data);
    end
    #1 chk("in_ready_at_accept", in_ready, 1);
    ctop = ref_c[op][TERMS-1];
    if (acc_wr) ref_c[op][wr_idx] = wr_data;
    expv = horner(ctop, op, v);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0; coef_we = 1'b0;
        var_i = MUL_BW'($urandom); shift_i = 5'($urandom);
        if (drop_wr) begin
          coef_we = 1'b1; coef_op = 2'(op); coef_idx = '0; coef_data = MUL_BW'($urandom);
        end
      end
      if (lat == 2) coef_we = 1'b0;
      if (out_valid) got = 1;
    end
    chk("latency", lat, TERMS);
    chk("res_o", $signed(res_o), expv);
    chk("shift_o", shift_o, sh);
    chk("op_o", op_o, op);
    if (hold) begin
      held = res_o;
      repeat (3) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_res", $signed(res_o), $signed(held));
        chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("valid_cleared", out_valid, 0);
    gemm_uno = '0;
  endtask

  initial begin
    logic signed [15:0] rv;
    int rop;
    for (int o = 1; o <= 3; o++)
      for (int k = 0; k < TERMS; k++) ref_c[o][k] = 0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res_o, 0);
    chk("rst_shift", shift_o, 0);
    chk("rst_op", op_o, 0);
    rst_n = 1'b1;

    // exp table
    wr(2, 0, 1024); wr(2, 1, 1024); wr(2, 2, 512); wr(2, 3, 171);
    run(2, 0, 7, 0, 0, 0, 0, 0);
    run(2, 512, 3, 0, 0, 0, 0, 0);
    // sign and floor
    wr(1, 0, 0); wr(1, 1, 1024); wr(1, 2, 0); wr(1, 3, 0);
    run(1, -1024, 1, 0, 0, 0, 0, 0);
    // saturation at every step
    for (int k = 0; k < TERMS; k++) wr(3, k, 32767);
    run(3, 32767, 31, 0, 0, 0, 0, 0);
    // stalled output + dropped write in EVAL, then read c0 back via v=0
    run(2, 512, 9, 1, 1, 0, 0, 0);
    run(2, 0, 2, 0, 0, 0, 0, 0);
    // gemm never accepted
    @(negedge clk);
    gemm_uno = 2'b00; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("gemm_in_ready", in_ready, 0);
      chk("gemm_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    // write coinciding with accept: top coef old, lower coefs new
    run(2, 700, 4, 0, 0, 1, 3, 2000);
    run(2, 700, 5, 0, 0, 1, 1, -900);

    // randomized tables and operands
    for (int i = 0; i < 40; i++) begin
      rop = $urandom_range(1, 3);
      if ($urandom_range(0, 2) == 0) begin
        rv = 16'($urandom);
        wr(rop, $urandom_range(0, TERMS-1), (i % 3 == 0) ? int'(rv) : int'(rv) / 16);
      end
      rv = 16'($urandom);
      run(rop, (i % 2 == 0) ? int'(rv) : int'(rv) / 32, $urandom_range(0, 31),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), $urandom_range(0, TERMS-1),
          int'(rv) / 8);
    end

    // reset during second EVAL cycle
    @(negedge clk);
    gemm_uno = 2'b10; in_valid = 1'b1; var_i = 16'sd512;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_res", res_o, 0);
    @(negedge clk);
    chk("midrst_held_valid", out_valid, 0);
    rst_n = 1'b1;
    for (int o = 1; o <= 3; o++)
      for (int k = 0; k < TERMS; k++) ref_c[o][k] = 0;
    run(2, 512, 6, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
